lower_part_or_addsub_pipe: RTL and testbench

//  Pipelined approximate adder/subtractor built on the lower-part-OR scheme.

---
 rtl/lower_part_or_addsub_pipe.sv | 112 +++++++++++
 tb/tb_lower_part_or_addsub_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lower_part_or_addsub_pipe.sv
// Two-stage lower-part-OR approximate adder/subtractor with valid/ready on both sides.
// The exact upper part is split at MID so each stage carries only half of the ripple chain.
module lower_part_or_addsub_pipe #(
   parameter int WIDTH = 32,
   parameter int LOWER = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             op_i,
   input  logic [WIDTH-1:0] add1_i,
   input  logic [WIDTH-1:0] add2_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             flag_o,
   output logic             op_o
);

   localparam int MID = LOWER + (WIDTH - LOWER) / 2;
   localparam int ML  = MID - LOWER;
   localparam int HL  = WIDTH - MID;

   logic [WIDTH-1:0] b_eff_s;
   logic             c_low_s;
   logic [ML:0]      mid_sum_s;
   logic [HL:0]      hi_sum_s;
   logic             s2_adv_s;
   logic             accept_s;

   logic             s1_valid_r;
   logic             s1_op_r;
   logic             s1_carry_r;
   logic [LOWER-1:0] s1_lo_r;
   logic [ML-1:0]    s1_mid_r;
   logic [HL-1:0]    s1_a_hi_r;
   logic [HL-1:0]    s1_b_hi_r;

   logic             out_valid_r;
   logic [WIDTH-1:0] result_r;
   logic             flag_r;
   logic             op_r;

   // Handshake: S2 frees up when empty or popped; S1 can take data whenever it can move on.
   always_comb begin
      s2_adv_s   = ~out_valid_r | out_ready_i;
      in_ready_o = ~s1_valid_r | s2_adv_s;
      accept_s   = in_valid_i & in_ready_o;
   end

   // Stage-1 arithmetic: subtraction uses ~b with no +1, so the OR part sees the inverted operand too.
   always_comb begin
      b_eff_s   = op_i ? ~add2_i : add2_i;
      c_low_s   = add1_i[LOWER-1] & b_eff_s[LOWER-1];
      mid_sum_s = {1'b0, add1_i[MID-1:LOWER]} + {1'b0, b_eff_s[MID-1:LOWER]}
                + {{ML{1'b0}}, c_low_s};
   end

   // Stage-2 arithmetic: finish the upper slice from the carry held in S1.
   always_comb begin
      hi_sum_s = {1'b0, s1_a_hi_r} + {1'b0, s1_b_hi_r} + {{HL{1'b0}}, s1_carry_r};
   end

   // S1 register: loads on accept, empties when it moves into S2 with nothing new behind it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_r <= 1'b0;
         s1_op_r    <= 1'b0;
         s1_carry_r <= 1'b0;
         s1_lo_r    <= {LOWER{1'b0}};
         s1_mid_r   <= {ML{1'b0}};
         s1_a_hi_r  <= {HL{1'b0}};
         s1_b_hi_r  <= {HL{1'b0}};
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_op_r    <= op_i;
         s1_carry_r <= mid_sum_s[ML];
         s1_lo_r    <= add1_i[LOWER-1:0] | b_eff_s[LOWER-1:0];
         s1_mid_r   <= mid_sum_s[ML-1:0];
         s1_a_hi_r  <= add1_i[WIDTH-1:MID];
         s1_b_hi_r  <= b_eff_s[WIDTH-1:MID];
      end else if (s2_adv_s) begin
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // S2 register: outputs hold while the consumer stalls; flag is inverted to a borrow for subtract.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_r <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         flag_r      <= 1'b0;
         op_r        <= 1'b0;
      end else if (s2_adv_s) begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            result_r <= {hi_sum_s[HL-1:0], s1_mid_r, s1_lo_r};
            flag_r   <= s1_op_r ? ~hi_sum_s[HL] : hi_sum_s[HL];
            op_r     <= s1_op_r;
         end
      end
   end

   assign out_valid_o = out_valid_r;
   assign result_o    = result_r;
   assign flag_o      = flag_r;
   assign op_o        = op_r;

endmodule

// File: tb/tb_lower_part_or_addsub_pipe.sv
// Self-checking bench: vector table for latency/values, plus scoreboard over stream, stall and reset sequences.
module tb_lower_part_or_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flag;
   logic        op_out;

   int n_checks = 0;
   int n_pass   = 0;
   int pop_cnt  = 0;
   logic [33:0] sb[$];

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        flag;
   } vec_t;
   vec_t tbl[11];

   lower_part_or_addsub_pipe #(.WIDTH(32), .LOWER(8)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .op_i(op), .add1_i(a), .add2_i(b), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .result_o(result), .flag_o(flag), .op_o(op_out)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] model(input logic mop, input logic [31:0] ma, input logic [31:0] mb);
      logic [31:0] bb;
      logic [24:0] up;
      bb = mop ? ~mb : mb;
      up = {1'b0, ma[31:8]} + {1'b0, bb[31:8]} + {24'd0, ma[7] & bb[7]};
      return {mop ? ~up[24] : up[24], up[23:0], ma[7:0] | bb[7:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard: push on accept, pop and compare on output handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL sb_unexpected: got result %0h expected no output", result);
            end else begin
               logic [33:0] e;
               e = sb.pop_front();
               check("sb_result", {32'd0, result}, {32'd0, e[31:0]});
               check("sb_flag", {63'd0, flag}, {63'd0, e[32]});
               check("sb_op", {63'd0, op_out}, {63'd0, e[33]});
            end
            pop_cnt++;
         end
         if (in_valid && in_ready) sb.push_back({op, model(op, a, b)});
      end
   end

   initial begin
      logic [31:0] held;
      logic        acc;
      int          k;
      int          base;
      logic [31:0] st_a[4];
      logic [31:0] st_b[4];

      tbl[0]  = '{1'b0, 32'h00000180, 32'h00000080, 32'h00000280, 1'b0};
      tbl[1]  = '{1'b1, 32'h00000500, 32'h00000100, 32'h000003FF, 1'b0};
      tbl[2]  = '{1'b1, 32'h00000000, 32'h00000100, 32'hFFFFFEFF, 1'b1};
      tbl[3]  = '{1'b0, 32'hFFFFFF80, 32'h00000080, 32'h00000080, 1'b1};
      tbl[4]  = '{1'b1, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b1};
      tbl[5]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
      tbl[6]  = '{1'b0, 32'h000FFF80, 32'h00000080, 32'h00100080, 1'b0};
      for (int i = 7; i < 11; i++) begin
         logic [32:0] m;
         tbl[i].op = 1'($urandom_range(0, 1));
         tbl[i].a  = $urandom;
         tbl[i].b  = $urandom;
         m = model(tbl[i].op, tbl[i].a, tbl[i].b);
         tbl[i].res  = m[31:0];
         tbl[i].flag = m[32];
      end

      rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0; out_ready = 1'b0;
      #12;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_outputs", {30'd0, op_out, flag, result}, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Single ops from idle: value and 2-clock latency.
      for (int i = 0; i < 11; i++) begin
         in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; out_ready = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("lat_not_early", {63'd0, out_valid}, 64'd0);
         @(posedge clk); #1;
         check("lat_valid", {63'd0, out_valid}, 64'd1);
         check("vec_result", {32'd0, result}, {32'd0, tbl[i].res});
         check("vec_flag", {63'd0, flag}, {63'd0, tbl[i].flag});
         check("vec_op", {63'd0, op_out}, {63'd0, tbl[i].op});
         @(posedge clk); #1;
         check("vec_drained", {63'd0, out_valid}, 64'd0);
      end

      // Streaming: full rate first, then random back-pressure.
      k = 0;
      op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      for (int cyc = 0; cyc < 400 && k < 30; cyc++) begin
         in_valid = 1'b1;
         out_ready = (k < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_ready;
         if (k > 0 && k < 8) check("full_rate_ready", {63'd0, in_ready}, 64'd1);
         @(posedge clk); #1;
         if (acc) begin
            k++;
            op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
      #1;
      check("stream_accepted", 64'(k), 64'd30);
      check("stream_drained", 64'(sb.size()), 64'd0);

      // Four back-to-back ops with the consumer stalled for 3 cycles.
      st_a = '{32'h00000010, 32'h00000200, 32'h00003000, 32'h00040000};
      st_b = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
      k = 0; base = pop_cnt; held = 32'd0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid = (k < 4);
         if (k < 4) begin op = 1'b0; a = st_a[k]; b = st_b[k]; end
         @(negedge clk);
         if (cyc == 2) begin
            check("stall_ready_drop", {63'd0, in_ready}, 64'd0);
            check("stall_accepts", 64'(k), 64'd2);
            held = result;
         end
         if (cyc == 3 || cyc == 4) begin
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_hold", {32'd0, result}, {32'd0, held});
         end
         if (in_valid && in_ready) k++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("stall_pops", 64'(pop_cnt - base), 64'd4);
      check("stall_sb_empty", 64'(sb.size()), 64'd0);

      // Reset with both stages full.
      out_ready = 1'b0; in_valid = 1'b1; op = 1'b0; a = 32'h00000111; b = 32'h00000022;
      @(posedge clk); #1;
      a = 32'h00000333; b = 32'h00000044;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      check("pre_rst_ready", {63'd0, in_ready}, 64'd0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", {63'd0, out_valid}, 64'd0);
      check("async_rst_ready", {63'd0, in_ready}, 64'd1);
      check("async_rst_result", {32'd0, result}, 64'd0);
      sb.delete();
      base = pop_cnt;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; op = 1'b1; a = 32'h00000900; b = 32'h00000300;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_pops", 64'(pop_cnt - base), 64'd1);
      check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
